conv_pe_fetch: RTL and testbench

- Clocked processing element that sits directly downstream of the shared memory node.
- Issues address-request packets for filter and ifmap data, consumes the data-response packets, and computes a FILTER_NUM x FILTER_NUM valid convolution over an IFMAP_NUM x IFMAP_NUM ifmap.
- Returns each output pixel to memory as a result packet (type 00), which memory appends to its final-result store.
- Exactly one request is outstanding at any time.

---
 rtl/conv_pe_fetch.sv | 195 +++++++++++++++++++
 tb/tb_conv_pe_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/conv_pe_fetch.sv
// rtl/conv_pe_fetch.sv - convolution PE that fetches filter/ifmap data from memory and returns result packets
module conv_pe_fetch #(
  parameter int DATA_WIDTH       = 20,
  parameter int WIDTH            = 5,
  parameter int VALID_DATA_WIDTH = 8,
  parameter int FILTER_NUM       = 3,
  parameter int IFMAP_NUM        = 7,
  parameter int ACC_WIDTH        = 20,
  parameter int PE_INDEX         = 1,
  parameter int MEM_INDEX        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_valid,
  input  logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  drop_pulse
);

  localparam int VW     = VALID_DATA_WIDTH;
  localparam int KNUM   = FILTER_NUM * FILTER_NUM;
  localparam int KW     = $clog2(KNUM);
  localparam int OW     = $clog2(IFMAP_NUM - FILTER_NUM + 1);
  localparam int K_LAST = KNUM - 1;
  localparam int O_LAST = IFMAP_NUM - FILTER_NUM;

  localparam logic [1:0] T_RES  = 2'b00;
  localparam logic [1:0] T_IFM  = 2'b01;
  localparam logic [1:0] T_FILT = 2'b10;

  typedef enum logic [2:0] {IDLE, F_REQ, F_WAIT, I_REQ, I_WAIT, R_SEND, DONE} state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          fcnt_q, fcnt_d;
  logic [KW-1:0]          k_q, k_d;
  logic [OW-1:0]          r_q, r_d;
  logic [OW-1:0]          c_q, c_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [VW-1:0]          w_q [KNUM];
  logic [VW-1:0]          w_d [KNUM];

  logic [1:0]             rsp_type;
  logic [WIDTH-1:0]       rsp_dst;
  logic [VW-1:0]          rsp_payload;
  logic                   rsp_match;
  logic [VW-1:0]          k_row, k_col, i_addr;
  logic [2*VW-1:0]        prod;
  logic                   unused_rsp_src;

  // Packets always travel from this PE to the memory node.
  function automatic logic [DATA_WIDTH-1:0] pkt(input logic [1:0] t, input logic [VW-1:0] p);
    return {t, WIDTH'(PE_INDEX), WIDTH'(MEM_INDEX), p};
  endfunction

  assign rsp_type       = rsp_data[DATA_WIDTH-1 -: 2];
  assign rsp_dst        = rsp_data[VW +: WIDTH];
  assign rsp_payload    = rsp_data[VW-1:0];
  assign unused_rsp_src = ^rsp_data[VW+WIDTH +: WIDTH];

  // Window address and MAC product for the current filter tap k.
  always_comb begin
    k_row     = VW'(k_q / KW'(FILTER_NUM));
    k_col     = VW'(k_q % KW'(FILTER_NUM));
    i_addr    = (VW'(r_q) + k_row) * VW'(IFMAP_NUM) + VW'(c_q) + k_col;
    prod      = (2*VW)'(w_q[k_q]) * (2*VW)'(rsp_payload);
    rsp_match = (rsp_dst == WIDTH'(PE_INDEX)) &&
                (rsp_type == ((state_q == F_WAIT) ? T_FILT : T_IFM));
  end

  // Next-state, counter and handshake logic; one request outstanding at a time.
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    k_d        = k_q;
    r_d        = r_q;
    c_d        = c_q;
    acc_d      = acc_q;
    w_d        = w_q;
    req_valid  = 1'b0;
    req_data   = '0;
    rsp_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    drop_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = F_REQ;
          fcnt_d  = '0;
        end
      end
      F_REQ: begin
        req_valid = 1'b1;
        req_data  = pkt(T_FILT, VW'(fcnt_q));
        if (req_ready) state_d = F_WAIT;
      end
      F_WAIT: begin
        rsp_ready = 1'b1;
        if (rsp_valid) begin
          if (rsp_match) begin
            w_d[fcnt_q] = rsp_payload;
            if (fcnt_q == KW'(K_LAST)) begin
              state_d = I_REQ;
              r_d     = '0;
              c_d     = '0;
              k_d     = '0;
              acc_d   = '0;
            end else begin
              fcnt_d  = fcnt_q + 1'b1;
              state_d = F_REQ;
            end
          end else begin
            drop_pulse = 1'b1;
          end
        end
      end
      I_REQ: begin
        req_valid = 1'b1;
        req_data  = pkt(T_IFM, i_addr);
        if (req_ready) state_d = I_WAIT;
      end
      I_WAIT: begin
        rsp_ready = 1'b1;
        if (rsp_valid) begin
          if (rsp_match) begin
            acc_d = acc_q + ACC_WIDTH'(prod);
            if (k_q == KW'(K_LAST)) begin
              state_d = R_SEND;
            end else begin
              k_d     = k_q + 1'b1;
              state_d = I_REQ;
            end
          end else begin
            drop_pulse = 1'b1;
          end
        end
      end
      R_SEND: begin
        req_valid = 1'b1;
        req_data  = pkt(T_RES, acc_q[VW-1:0]);
        if (req_ready) begin
          acc_d   = '0;
          k_d     = '0;
          state_d = I_REQ;
          if (c_q == OW'(O_LAST)) begin
            c_d = '0;
            if (r_q == OW'(O_LAST)) begin
              r_d     = '0;
              state_d = DONE;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, accumulator and weights; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      k_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      w_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      k_q     <= k_d;
      r_q     <= r_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
    end
  end

endmodule

// File: tb/tb_conv_pe_fetch.sv
// tb/tb_conv_pe_fetch.sv - directed testbench for conv_pe_fetch with a simple memory model
module tb_conv_pe_fetch;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [19:0] req_data, rsp_data;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic        busy, done, drop_pulse;

  always #5 clk = ~clk;

  conv_pe_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .rsp_data   (rsp_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .busy       (busy),
    .done       (done),
    .drop_pulse (drop_pulse)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  filt [9];
  logic [19:0] res [25];
  logic [19:0] reqlog [256];
  int          nres, nreq, ndone, ndrop;
  logic [19:0] rq [$];
  bit          bq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pkt(input logic [1:0] t, input logic [4:0] s,
                                      input logic [4:0] d, input logic [7:0] p);
    return {t, s, d, p};
  endfunction

  function automatic logic [7:0] exp_pix(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(filt[i*3+j]) * ((r + i) * 7 + c + j);
    return 8'(s);
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_data"}, req_data, 0);
    check({tag, "_req_valid"}, req_valid, 0);
    check({tag, "_rsp_ready"}, rsp_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_drop"}, drop_pulse, 0);
  endtask

  task automatic run_job(input int stall_req, input int bad1, input int bad2,
                         input int abort_res, input int start2);
    int          stall_left = 0;
    bit          stall_done = 0;
    logic [19:0] hold = '0;
    int          done_cyc = -1;
    bit          fin = 0;
    logic [7:0]  addr;
    logic [1:0]  tp;
    nres = 0; nreq = 0; ndone = 0; ndrop = 0;
    rq.delete(); bq.delete();
    for (int i = 0; i < 25; i++) res[i] = '1;
    for (int i = 0; i < 256; i++) reqlog[i] = '1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (abort_res >= 0 && nres == abort_res && rsp_ready) begin
        rst = 1'b1; start = 1'b0; req_ready = 1'b1;
        rsp_valid = (rq.size() > 0);
        rsp_data  = (rq.size() > 0) ? rq[0] : '0;
        @(posedge clk);
        #1;
        rst = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        check_outputs_zero("abort");
        return;
      end
      start = (cyc == 0) || (cyc == start2);
      if (!stall_done && stall_req >= 0 && nreq == stall_req && req_valid) begin
        stall_left = 5; stall_done = 1; hold = req_data;
      end
      req_ready = (stall_left == 0);
      rsp_valid = (rq.size() > 0);
      rsp_data  = (rq.size() > 0) ? rq[0] : '0;
      #1;
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (stall_left > 0) begin
        check("stall_valid", req_valid, 1);
        check("stall_data", req_data, hold);
        stall_left--;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check("busy_at_done", busy, 0);
        end
      end
      if (drop_pulse) ndrop++;
      if (rsp_valid && rsp_ready) begin
        check("drop_pulse", drop_pulse, bq[0]);
        void'(rq.pop_front());
        void'(bq.pop_front());
      end
      if (req_valid && req_ready) begin
        tp   = req_data[19:18];
        addr = req_data[7:0];
        if (tp == 2'b00) begin
          if (nres < 25) res[nres] = req_data;
          nres++;
        end else begin
          if (nreq < 256) reqlog[nreq] = req_data;
          if (nreq == bad1) begin rq.push_back(pkt(2'b01, 5'd0, 5'd3, 8'hAA)); bq.push_back(1'b1); end
          if (nreq == bad2) begin rq.push_back(pkt(2'b00, 5'd0, 5'd1, 8'hBB)); bq.push_back(1'b1); end
          rq.push_back(pkt(tp, 5'd0, 5'd1,
                           (tp == 2'b10) ? ((addr < 8'd9) ? filt[addr[3:0]] : 8'h00) : addr));
          bq.push_back(1'b0);
          nreq++;
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) begin
        fin = 1;
        break;
      end
    end
    start = 1'b0;
    rsp_valid = 1'b0;
    if (!fin) check("job_timeout", 0, 1);
  endtask

  task automatic verify(input string tag, input int exp_drop);
    int r, c;
    check({tag, "_results"}, nres, 25);
    check({tag, "_done_count"}, ndone, 1);
    check({tag, "_requests"}, nreq, 234);
    check({tag, "_drops"}, ndrop, exp_drop);
    for (int i = 0; i < 9; i++)
      check({tag, "_filt_req"}, reqlog[i], pkt(2'b10, 5'd1, 5'd0, 8'(i)));
    for (int p = 0; p < 25; p++) begin
      r = p / 5;
      c = p % 5;
      check({tag, "_result"}, res[p], pkt(2'b00, 5'd1, 5'd0, exp_pix(r, c)));
      for (int k = 0; k < 9; k++)
        check({tag, "_ifm_req"}, reqlog[9 + p*9 + k],
              pkt(2'b01, 5'd1, 5'd0, 8'((r + k/3) * 7 + c + k%3)));
    end
  endtask

  initial begin
    int tr [9] = '{1, 2, 3, 8, 9, 10, 15, 16, 17};
    rst = 1'b1; start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) filt[i] = 8'd1;
    run_job(-1, -1, -1, -1, -1);
    verify("base", 0);
    check("first_result_pkt", res[0], 20'h02048);
    check("pix22_payload", res[12][7:0], 216);
    check("pix44_payload", res[24][7:0], 104);
    for (int j = 0; j < 9; j++) check("pix01_trace", reqlog[18 + j][7:0], tr[j]);

    run_job(20, -1, -1, -1, -1);
    verify("stall", 0);

    for (int i = 0; i < 9; i++) filt[i] = 8'(i + 1);
    run_job(-1, 14, 60, -1, -1);
    verify("drop", 2);

    for (int i = 0; i < 9; i++) filt[i] = 8'd1;
    run_job(-1, -1, -1, 10, -1);
    run_job(-1, -1, -1, -1, -1);
    verify("restart", 0);

    run_job(-1, -1, -1, -1, 50);
    verify("restart_start", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
